// File: rtl/sum_carry_demux_pkg.sv
// ============================================================================
// Module   : sum_carry_pkg
// Brief    : Shared types and constants for the sum/carry result demux.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sum_carry_pkg;

    localparam int C_BUS_W = 4;
    localparam int C_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        CARRY_PH = 2'b01,
        SUM_PH   = 2'b10
    } state_t;

    // A carry arrives zero-extended, so any upper bit set means a corrupt nibble.
    function automatic logic carry_malformed(input logic [C_BUS_W-1:0] nib);
        return |nib[C_BUS_W-1:1];
    endfunction

endpackage

`default_nettype wire

// File: rtl/sum_carry_demux_if.sv
// ============================================================================
// Module   : sum_carry_demux_if
// Brief    : Result-bus and reconstructed-output bundle for sum_carry_demux.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sum_carry_demux_if
    import sum_carry_pkg::*;
#(
    parameter int W = C_BUS_W
);

    logic         en;
    logic [W-1:0] bus_in;
    logic         sel;
    logic [W-1:0] sum_out;
    logic         cout_out;
    logic         valid;
    logic         frame_err;

    // Demux side
    modport master (
        input  en,
        input  bus_in,
        output sel,
        output sum_out,
        output cout_out,
        output valid,
        output frame_err
    );

    // Mux / consumer side
    modport slave (
        output en,
        output bus_in,
        input  sel,
        input  sum_out,
        input  cout_out,
        input  valid,
        input  frame_err
    );

endinterface

`default_nettype wire

// File: rtl/sum_carry_demux_dwell_counter.sv
// ============================================================================
// Module   : dwell_counter
// Brief    : Phase dwell counter; flags the final cycle of a phase and wraps.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dwell_counter
    import sum_carry_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic [C_CNT_W-1:0] limit,
    output logic               last
);

    logic [C_CNT_W-1:0] r_count;

    assign last = (r_count == (limit - C_CNT_W'(1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear || last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + C_CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/sum_carry_demux.sv
// ============================================================================
// Module   : sum_carry_demux
// Brief    : Drives the result-mux select and rebuilds sum/carry from the bus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sum_carry_demux
    import sum_carry_pkg::*;
#(
    parameter int DWELL = 4,
    parameter int W     = C_BUS_W
)(
    input  logic               clk,
    input  logic               rst,
    sum_carry_demux_if.master  bus
);

    localparam logic [C_CNT_W-1:0] C_LIMIT = C_CNT_W'(DWELL);

    state_t       r_state;
    state_t       w_next;
    logic         w_last;
    logic         w_clear;
    logic         w_carry_sample;
    logic         w_sum_sample;

    logic         r_carry;
    logic [W-1:0] r_sum;
    logic         r_cout;
    logic         r_valid;
    logic         r_err;
    logic         r_sel;

    // Holding the counter cleared in IDLE keeps it from free-running between frames.
    assign w_clear = (r_state == IDLE);

    dwell_counter u_dwell (
        .clk   (clk),
        .rst   (rst),
        .clear (w_clear),
        .limit (C_LIMIT),
        .last  (w_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next         = r_state;
        w_carry_sample = 1'b0;
        w_sum_sample   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.en) begin
                    w_next = CARRY_PH;
                end
            end
            CARRY_PH: begin
                if (w_last) begin
                    w_carry_sample = 1'b1;
                    w_next         = SUM_PH;
                end
            end
            SUM_PH: begin
                if (w_last) begin
                    w_sum_sample = 1'b1;
                    w_next       = bus.en ? CARRY_PH : IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // sel comes from a flop loaded with the next state, so it cannot glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel   <= 1'b0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_sel   <= (w_next == SUM_PH);
            r_valid <= 1'b0;
            if (w_carry_sample) begin
                r_carry <= bus.bus_in[0];
                if (carry_malformed(bus.bus_in)) begin
                    r_err <= 1'b1;
                end
            end
            if (w_sum_sample) begin
                r_sum   <= bus.bus_in;
                r_cout  <= r_carry;
                r_valid <= 1'b1;
            end
        end
    end

    assign bus.sel       = r_sel;
    assign bus.sum_out   = r_sum;
    assign bus.cout_out  = r_cout;
    assign bus.valid     = r_valid;
    assign bus.frame_err = r_err;

endmodule

`default_nettype wire
